// File: rtl/load_store_queue.sv
// In-order load/store buffer acting as functional-unit slot 3 of the Tomasulo core.
// Issued lw/sw entries wait here until their base and store-data operands arrive
// over the CDB. The head entry then performs one memory access. A load then
// requests the CDB to broadcast its result.
module load_store_queue #(
  parameter int                  DEPTH      = 4,
  parameter int                  DATA_W     = 32,
  parameter int                  LABEL_W    = 4,
  parameter logic [LABEL_W-1:0]  LABEL_BASE = 4'd12
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               WEN,
  input  logic               isStore,
  input  logic [DATA_W-1:0]  Vj,
  input  logic [LABEL_W-1:0] Qj,
  input  logic [DATA_W-1:0]  Vk,
  input  logic [LABEL_W-1:0] Qk,
  input  logic [15:0]        offset,
  output logic               isFull,
  output logic [LABEL_W-1:0] labelOut,
  input  logic               BCEN,
  input  logic [LABEL_W-1:0] BClabel,
  input  logic [DATA_W-1:0]  BCdata,
  output logic               require,
  input  logic               requireAC,
  output logic [DATA_W-1:0]  result,
  output logic [LABEL_W-1:0] resultLabel,
  output logic               mem_req,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_ack,
  input  logic [DATA_W-1:0]  mem_rdata
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] BCAST  = 2'd2;

  // Byte address = base + sign-extended immd16, wrapping modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] eff_addr(input logic [DATA_W-1:0] base,
                                                 input logic [15:0]       off);
    logic signed [DATA_W-1:0] off_ext;
    off_ext = DATA_W'($signed(off));
    return base + off_ext;
  endfunction

  logic [DEPTH-1:0]   e_valid;
  logic [DEPTH-1:0]   e_store;
  logic [DATA_W-1:0]  e_vj  [DEPTH];
  logic [LABEL_W-1:0] e_qj  [DEPTH];
  logic [DATA_W-1:0]  e_vk  [DEPTH];
  logic [LABEL_W-1:0] e_qk  [DEPTH];
  logic [15:0]        e_off [DEPTH];

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [1:0]       state;

  logic head_ready;
  logic launch;
  logic enq;
  logic deq;

  assign isFull   = (count == CNT_W'(DEPTH));
  assign labelOut = LABEL_BASE + LABEL_W'(tail);
  assign require  = (state == BCAST);

  // Stores additionally need their data operand before they may start.
  assign head_ready = e_valid[head] && (e_qj[head] == '0) &&
                      (!e_store[head] || (e_qk[head] == '0));
  assign launch = (state == IDLE) && head_ready;
  assign enq    = WEN && !isFull;
  assign deq    = ((state == ACCESS) && mem_ack && mem_we) ||
                  ((state == BCAST) && requireAC);

  // Queue storage: CDB snoop, tail enqueue with same-cycle bypass, head dequeue.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      e_valid <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (e_valid[i] && BCEN) begin
          if ((e_qj[i] != '0) && (BClabel == e_qj[i])) begin
            e_vj[i] <= BCdata;
            e_qj[i] <= '0;
          end
          if ((e_qk[i] != '0) && (BClabel == e_qk[i])) begin
            e_vk[i] <= BCdata;
            e_qk[i] <= '0;
          end
        end
      end
      if (enq) begin
        e_valid[tail] <= 1'b1;
        e_store[tail] <= isStore;
        e_off[tail]   <= offset;
        if (BCEN && (Qj != '0) && (BClabel == Qj)) begin
          e_vj[tail] <= BCdata;
          e_qj[tail] <= '0;
        end else begin
          e_vj[tail] <= Vj;
          e_qj[tail] <= Qj;
        end
        if (BCEN && (Qk != '0) && (BClabel == Qk)) begin
          e_vk[tail] <= BCdata;
          e_qk[tail] <= '0;
        end else begin
          e_vk[tail] <= Vk;
          e_qk[tail] <= Qk;
        end
        tail <= tail + IDX_W'(1);
      end
      if (deq) begin
        e_valid[head] <= 1'b0;
        head          <= head + IDX_W'(1);
      end
      count <= count + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // Head-of-queue access FSM: IDLE -> ACCESS -> (BCAST for loads) -> IDLE.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      result      <= '0;
      resultLabel <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state   <= ACCESS;
            mem_req <= 1'b1;
            mem_we  <= e_store[head];
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              state <= IDLE;
            end else begin
              result      <= mem_rdata;
              resultLabel <= LABEL_BASE + LABEL_W'(head);
              state       <= BCAST;
            end
          end
        end
        BCAST: begin
          if (requireAC) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Access address/data are captured at launch and held for the whole access.
  always_ff @(posedge clk) begin
    if (launch) begin
      mem_addr  <= eff_addr(e_vj[head], e_off[head]);
      mem_wdata <= e_vk[head];
    end
  end

endmodule

// File: tb/tb_load_store_queue.sv
// Bench for load_store_queue: directed vectors with literal expectations plus a
// transaction-level queue model checked against the DUT on every falling edge.
module tb_load_store_queue;

  logic        clk = 1'b0;
  logic        nRST;
  logic        WEN;
  logic        isStore;
  logic [31:0] Vj;
  logic [3:0]  Qj;
  logic [31:0] Vk;
  logic [3:0]  Qk;
  logic [15:0] offset;
  logic        isFull;
  logic [3:0]  labelOut;
  logic        BCEN;
  logic [3:0]  BClabel;
  logic [31:0] BCdata;
  logic        require;
  logic        requireAC;
  logic [31:0] result;
  logic [3:0]  resultLabel;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  load_store_queue dut (
    .clk(clk), .nRST(nRST), .WEN(WEN), .isStore(isStore),
    .Vj(Vj), .Qj(Qj), .Vk(Vk), .Qk(Qk), .offset(offset),
    .isFull(isFull), .labelOut(labelOut),
    .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata),
    .require(require), .requireAC(requireAC),
    .result(result), .resultLabel(resultLabel),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          st;
    logic [31:0] vj;
    logic [3:0]  qj;
    logic [31:0] vk;
    logic [3:0]  qk;
    logic [15:0] off;
    logic [3:0]  label;
  } ent_t;

  ent_t        mq[$];
  ent_t        ne;
  int          m_tail  = 0;
  bit          m_bcast = 0;
  logic [31:0] m_res   = '0;
  logic [3:0]  m_reslab = '0;
  bit          s_req = 0;
  bit          s_require = 0;
  bit          chk_en = 0;
  bit          do_enq;
  bit          do_deq;

  function automatic logic [31:0] addr_of(input ent_t e);
    return e.vj + {{16{e.off[15]}}, e.off};
  endfunction

  // Model update on each rising edge, from inputs and the outputs seen this cycle.
  always @(posedge clk) begin
    if (!nRST) begin
      mq.delete();
      m_tail = 0; m_bcast = 0; m_res = '0; m_reslab = '0;
    end else begin
      do_enq = WEN && (mq.size() < 4);
      do_deq = 0;
      if (s_req && mem_ack && mq.size() > 0) begin
        if (mq[0].st) do_deq = 1;
        else begin
          m_bcast = 1; m_res = mem_rdata; m_reslab = mq[0].label;
        end
      end
      if (s_require && requireAC) begin
        m_bcast = 0; do_deq = 1;
      end
      foreach (mq[i]) begin
        if (BCEN && mq[i].qj != 0 && BClabel == mq[i].qj) begin mq[i].vj = BCdata; mq[i].qj = 0; end
        if (BCEN && mq[i].qk != 0 && BClabel == mq[i].qk) begin mq[i].vk = BCdata; mq[i].qk = 0; end
      end
      if (do_enq) begin
        ne.st = isStore; ne.off = offset; ne.label = 4'(12 + m_tail);
        if (BCEN && Qj != 0 && BClabel == Qj) begin ne.vj = BCdata; ne.qj = 0; end
        else begin ne.vj = Vj; ne.qj = Qj; end
        if (BCEN && Qk != 0 && BClabel == Qk) begin ne.vk = BCdata; ne.qk = 0; end
        else begin ne.vk = Vk; ne.qk = Qk; end
        mq.push_back(ne);
        m_tail = (m_tail + 1) % 4;
      end
      if (do_deq && mq.size() > 0) void'(mq.pop_front());
    end
  end

  // Compare process on the falling edge.
  always @(negedge clk) begin
    bit head_ok;
    if (chk_en) begin
      head_ok = (mq.size() > 0) && !m_bcast && (mq[0].qj == 0) &&
                (!mq[0].st || mq[0].qk == 0);
      chk("m_isFull", {31'b0, isFull}, {31'b0, mq.size() == 4});
      chk("m_labelOut", {28'b0, labelOut}, 32'(12 + m_tail));
      chk("m_require", {31'b0, require}, {31'b0, m_bcast});
      chk("m_result", result, m_res);
      chk("m_resultLabel", {28'b0, resultLabel}, {28'b0, m_reslab});
      chk("m_req_legal", {31'b0, mem_req & ~head_ok}, 32'd0);
      if (mem_req && head_ok) begin
        chk("m_mem_addr", mem_addr, addr_of(mq[0]));
        chk("m_mem_we", {31'b0, mem_we}, {31'b0, mq[0].st});
        if (mq[0].st) chk("m_mem_wdata", mem_wdata, mq[0].vk);
      end
    end
    s_req = mem_req;
    s_require = require;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit st, input logic [31:0] vj, input logic [3:0] qj,
                       input logic [31:0] vk, input logic [3:0] qk, input logic [15:0] off);
    WEN = 1; isStore = st; Vj = vj; Qj = qj; Vk = vk; Qk = qk; offset = off;
    tick();
    WEN = 0; isStore = 0; Vj = 0; Qj = 0; Vk = 0; Qk = 0; offset = 0;
  endtask

  task automatic bcast(input logic [3:0] lab, input logic [31:0] d);
    BCEN = 1; BClabel = lab; BCdata = d;
    tick();
    BCEN = 0; BClabel = 0; BCdata = 0;
  endtask

  task automatic ack(input logic [31:0] rd);
    mem_ack = 1; mem_rdata = rd;
    tick();
    mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic grant();
    requireAC = 1;
    tick();
    requireAC = 0;
  endtask

  task automatic wait_req(input int max, input string nm);
    int n = 0;
    while (mem_req !== 1'b1 && n < max) begin tick(); n++; end
    chk(nm, {31'b0, mem_req}, 32'd1);
  endtask

  logic [3:0] exp_lab [4];

  initial begin
    nRST = 0; WEN = 0; isStore = 0; Vj = 0; Qj = 0; Vk = 0; Qk = 0; offset = 0;
    BCEN = 0; BClabel = 0; BCdata = 0; requireAC = 0; mem_ack = 0; mem_rdata = 0;
    tick(); tick();
    chk("rst_isFull", {31'b0, isFull}, 32'd0);
    chk("rst_require", {31'b0, require}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_resultLabel", {28'b0, resultLabel}, 32'd0);
    chk("rst_labelOut", {28'b0, labelOut}, 32'd12);
    nRST = 1;
    chk_en = 1;
    tick();

    // lw Vj=0x100 off=4, ack after 2 cycles with 0xDEAD
    issue(0, 32'h100, 0, 0, 0, 16'd4);
    chk("lw_labelOut", {28'b0, labelOut}, 32'd13);
    chk("lw_req_not_yet", {31'b0, mem_req}, 32'd0);
    tick();
    chk("lw_req", {31'b0, mem_req}, 32'd1);
    chk("lw_addr", mem_addr, 32'h104);
    chk("lw_we", {31'b0, mem_we}, 32'd0);
    tick(); tick();
    chk("lw_req_held", {31'b0, mem_req}, 32'd1);
    chk("lw_addr_held", mem_addr, 32'h104);
    ack(32'hDEAD);
    chk("lw_require", {31'b0, require}, 32'd1);
    chk("lw_result", result, 32'hDEAD);
    chk("lw_resultLabel", {28'b0, resultLabel}, 32'd12);
    chk("lw_req_dropped", {31'b0, mem_req}, 32'd0);
    grant();
    chk("lw_require_clr", {31'b0, require}, 32'd0);

    // sw waiting on tag 3 for its data
    issue(1, 32'h200, 0, 0, 4'd3, 16'd8);
    tick(); tick(); tick();
    chk("sw_waits", {31'b0, mem_req}, 32'd0);
    bcast(4'd3, 32'h55);
    chk("sw_capture_cycle", {31'b0, mem_req}, 32'd0);
    tick();
    chk("sw_req", {31'b0, mem_req}, 32'd1);
    chk("sw_we", {31'b0, mem_we}, 32'd1);
    chk("sw_wdata", mem_wdata, 32'h55);
    chk("sw_addr", mem_addr, 32'h208);
    ack(32'h0);
    chk("sw_done_req", {31'b0, mem_req}, 32'd0);
    chk("sw_no_require", {31'b0, require}, 32'd0);
    tick();
    chk("sw_idle_gap", {31'b0, mem_req}, 32'd0);

    // fill with 4 loads waiting on tag 5
    exp_lab[0] = 4'd14; exp_lab[1] = 4'd15; exp_lab[2] = 4'd12; exp_lab[3] = 4'd13;
    for (int i = 0; i < 4; i++) begin
      chk("fill_labelOut", {28'b0, labelOut}, {28'b0, exp_lab[i]});
      issue(0, 32'h0, 4'd5, 0, 0, 16'(i * 4));
    end
    chk("fill_isFull", {31'b0, isFull}, 32'd1);
    chk("fill_labelOut_wrap", {28'b0, labelOut}, 32'd14);
    issue(0, 32'h999, 0, 0, 0, 16'd0);
    chk("fifth_ignored_full", {31'b0, isFull}, 32'd1);
    chk("fifth_ignored_label", {28'b0, labelOut}, 32'd14);
    bcast(4'd5, 32'h3000);
    for (int i = 0; i < 4; i++) begin
      wait_req(10, "drain_req");
      chk("drain_addr", mem_addr, 32'h3000 + 32'(i * 4));
      ack(32'hA0 + 32'(i));
      chk("drain_result", result, 32'hA0 + 32'(i));
      chk("drain_label", {28'b0, resultLabel}, {28'b0, exp_lab[i]});
      grant();
    end
    chk("drain_empty", {31'b0, isFull}, 32'd0);

    // bypass: issue with Qj=7 while tag 7 is on the CDB
    BCEN = 1; BClabel = 4'd7; BCdata = 32'h400;
    issue(0, 32'h0, 4'd7, 0, 0, 16'h10);
    BCEN = 0; BClabel = 0; BCdata = 0;
    tick();
    chk("byp_req", {31'b0, mem_req}, 32'd1);
    chk("byp_addr", mem_addr, 32'h410);
    ack(32'h77);
    chk("byp_label", {28'b0, resultLabel}, 32'd14);
    grant();

    // negative offset wrap and held grant
    issue(0, 32'h0, 0, 0, 0, 16'hFFFC);
    wait_req(4, "wrap_req");
    chk("wrap_addr", mem_addr, 32'hFFFFFFFC);
    ack(32'hBEEF);
    for (int i = 0; i < 5; i++) begin
      chk("hold_require", {31'b0, require}, 32'd1);
      chk("hold_result", result, 32'hBEEF);
      tick();
    end
    chk("hold_label", {28'b0, resultLabel}, 32'd15);
    grant();

    // reset during an access
    issue(0, 32'h50, 0, 0, 0, 16'd0);
    wait_req(4, "rst_acc_req");
    nRST = 0;
    tick();
    nRST = 1;
    chk("rst_acc_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_acc_isFull", {31'b0, isFull}, 32'd0);
    chk("rst_acc_require", {31'b0, require}, 32'd0);
    chk("rst_acc_labelOut", {28'b0, labelOut}, 32'd12);
    issue(0, 32'h60, 0, 0, 0, 16'd0);
    wait_req(4, "post_rst_req");
    chk("post_rst_addr", mem_addr, 32'h60);
    ack(32'h1234);
    chk("post_rst_label", {28'b0, resultLabel}, 32'd12);
    grant();
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
